// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - EX-stage multiply/divide unit owning HI/LO with modelled multi-cycle latency
module ex_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic        HIWrite,
    input  logic        LOWrite,
    input  logic        HIRead,
    input  logic        LORead,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  count;
    logic [31:0]    pend_hi, pend_lo;
    logic           pend_wr;

    logic           op_legal, op_div, op_signed_div;
    logic           acc, done, mt_hi, mt_lo;
    logic [63:0]    prod_s, prod_u;
    logic [31:0]    abs_a, abs_b, num, den, den_safe, quo, rem;
    logic [31:0]    res_hi, res_lo;
    logic           res_wr;
    logic [CW-1:0]  load_count;

    assign op_legal      = (MDUOp >= 4'd1) && (MDUOp <= 4'd4);
    assign op_div        = (MDUOp == 4'd3) || (MDUOp == 4'd4);
    assign op_signed_div = (MDUOp == 4'd3);

    assign Busy   = (state == BUSY);
    assign acc    = Start && !Req && !Busy && op_legal;
    assign done   = (state == BUSY) && (count == CW'(1));
    // A Start in the same cycle takes priority over MTHI/MTLO.
    assign mt_hi  = HIWrite && !Req && !Busy && !Start;
    assign mt_lo  = LOWrite && !Req && !Busy && !Start;
    assign MDUOut = HIRead ? HI : (LORead ? LO : 32'd0);

    // Signed product via sign-extension; the low 64 bits of the wide product are exact.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // One unsigned divider serves both DIV (on magnitudes) and DIVU.
    assign abs_a    = A[31] ? (~A + 32'd1) : A;
    assign abs_b    = B[31] ? (~B + 32'd1) : B;
    assign num      = op_signed_div ? abs_a : A;
    assign den      = op_signed_div ? abs_b : B;
    assign den_safe = (den == 32'd0) ? 32'd1 : den;
    assign quo      = num / den_safe;
    assign rem      = num % den_safe;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b1;
        case (MDUOp)
            4'd1: {res_hi, res_lo} = prod_s;
            4'd2: {res_hi, res_lo} = prod_u;
            4'd3: begin
                res_lo = (A[31] ^ B[31]) ? (~quo + 32'd1) : quo;
                res_hi = A[31] ? (~rem + 32'd1) : rem;
                res_wr = (B != 32'd0);
            end
            4'd4: begin
                res_lo = quo;
                res_hi = rem;
                res_wr = (B != 32'd0);
            end
            default: res_wr = 1'b0;
        endcase
    end

    assign load_count = op_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (acc) state_next = BUSY;
            BUSY:    if (count == CW'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            state <= state_next;
            if (acc) begin
                count   <= load_count;
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= res_wr;
            end else if (state == BUSY) begin
                count <= count - CW'(1);
            end
            if (done) begin
                if (pend_wr) begin
                    HI <= pend_hi;
                    LO <= pend_lo;
                end
            end else begin
                if (mt_hi) HI <= A;
                if (mt_lo) LO <= A;
            end
        end
    end

endmodule
